// File: rtl/pipe_reg_skid_pkg.sv
// Shared pipeline definitions: control-field bit positions and the skid-buffer state encoding.
package pipe_reg_skid_pkg;

    localparam int unsigned REG_WRITE_BIT  = 0;
    localparam int unsigned MEM_WRITE_BIT  = 1;
    localparam int unsigned RESULT_SRC_LSB = 2;
    localparam int unsigned RESULT_SRC_W   = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skidState_e;

endpackage

// File: rtl/pipe_reg_skid.sv
// EX/MEM pipeline register with a one-entry skid buffer; in_ready depends only on held state.
module pipe_reg_skid
    import pipe_reg_skid_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic [3*XLEN-1:0]   in_data,
    input  logic [RD_W-1:0]     in_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [3*XLEN-1:0]   out_data,
    output logic [RD_W-1:0]     out_rd,
    output logic [CNT_W-1:0]    stall_cnt
);

    skidState_e stateQ, stateD;

    logic [CTRL_W-1:0]  mainCtrlQ, skidCtrlQ;
    logic [3*XLEN-1:0]  mainDataQ, skidDataQ;
    logic [RD_W-1:0]    mainRdQ, skidRdQ;
    logic [CNT_W-1:0]   stallCntQ;

    logic accept, pop;
    logic loadMainIn, loadSkidIn, loadMainSkid;

    assign in_ready  = (stateQ != FULL);
    assign out_valid = (stateQ != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stateQ <= EMPTY;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD       = stateQ;
        loadMainIn   = 1'b0;
        loadSkidIn   = 1'b0;
        loadMainSkid = 1'b0;
        if (flush) begin
            stateD = EMPTY;
        end else begin
            unique case (stateQ)
                EMPTY: begin
                    if (accept) begin
                        stateD     = ONE;
                        loadMainIn = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        loadMainIn = 1'b1;
                    end else if (accept) begin
                        stateD     = FULL;
                        loadSkidIn = 1'b1;
                    end else if (pop) begin
                        stateD = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        stateD       = ONE;
                        loadMainSkid = 1'b1;
                    end
                end
                default: stateD = EMPTY;
            endcase
        end
    end

    // Payload registers only move on an explicit load, keeping the head stable under backpressure.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mainCtrlQ <= '0;
            mainDataQ <= '0;
            mainRdQ   <= '0;
            skidCtrlQ <= '0;
            skidDataQ <= '0;
            skidRdQ   <= '0;
        end else begin
            if (loadMainIn) begin
                mainCtrlQ <= in_ctrl;
                mainDataQ <= in_data;
                mainRdQ   <= in_rd;
            end else if (loadMainSkid) begin
                mainCtrlQ <= skidCtrlQ;
                mainDataQ <= skidDataQ;
                mainRdQ   <= skidRdQ;
            end
            if (loadSkidIn) begin
                skidCtrlQ <= in_ctrl;
                skidDataQ <= in_data;
                skidRdQ   <= in_rd;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stallCntQ <= '0;
        end else if (out_valid && !out_ready && (stallCntQ != '1)) begin
            stallCntQ <= stallCntQ + 1'b1;
        end
    end

    // A bubble must never carry a register or memory write downstream.
    always_comb begin
        out_ctrl = mainCtrlQ;
        if (!out_valid) begin
            out_ctrl                                 = '0;
            out_ctrl[REG_WRITE_BIT]                  = 1'b0;
            out_ctrl[MEM_WRITE_BIT]                  = 1'b0;
            out_ctrl[RESULT_SRC_LSB +: RESULT_SRC_W] = '0;
        end
    end

    assign out_data  = mainDataQ;
    assign out_rd    = mainRdQ;
    assign stall_cnt = stallCntQ;

endmodule

// File: doc/pipe_reg_skid.md
PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of each data field.
REQ-002 SHALL have parameter RD_W, default 5, destination-register index width.
REQ-003 SHALL have parameter CTRL_W, default 4, control width; bit0 reg_write, bit1 mem_write, bits[3:2] result_src.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL have port CLK  input  1  sole clock, rising-edge.
REQ-006 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous kill of all held and incoming entries.
REQ-008 SHALL have port in_valid  input  1  upstream (EX) entry present.
REQ-009 SHALL have port in_ready  output  1  block accepts an entry this cycle.
REQ-010 SHALL have port in_ctrl  input  CTRL_W  control bits per REQ-003.
REQ-011 SHALL have port in_data  input  3*XLEN  packed {pc_plus4, write_data, alu_result}, alu_result in LSBs.
REQ-012 SHALL have port in_rd  input  RD_W  destination register index.
REQ-013 SHALL have port out_valid  output  1  downstream (MEM) entry present.
REQ-014 SHALL have port out_ready  input  1  downstream consumes entry this cycle.
REQ-015 SHALL have ports out_ctrl, out_data, out_rd  output  CTRL_W, 3*XLEN, RD_W  head-entry payload.
REQ-016 SHALL have port stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 SHALL hold at most two entries (main, skid) in FIFO order; out_* always present the main entry.
REQ-018 SHALL implement states EMPTY (no entries), ONE (main only), FULL (main+skid).
REQ-019 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL; in_ready is a registered function of state, with no combinational path from out_ready.
REQ-020 SHALL accept when in_valid & in_ready; SHALL pop when out_valid & out_ready.
REQ-021 Transitions: EMPTY+accept->ONE; ONE+accept+pop->ONE (main<=input); ONE+accept, no pop->FULL (skid<=input); ONE+pop, no accept->EMPTY; FULL+pop->ONE (main<=skid); otherwise hold.
REQ-022 SHALL give 1-cycle latency: an entry accepted in EMPTY appears on out_* the next cycle.
REQ-023 SHALL drive out_valid = 1 in ONE and FULL, 0 in EMPTY.
REQ-024 SHALL force out_ctrl to all-zero whenever out_valid = 0 (bubble: no reg/mem write); out_data and out_rd are don't-care then.
REQ-025 SHALL, on flush = 1, go to EMPTY next cycle, dropping held entries and any same-cycle input; flush has priority over accept and pop.
REQ-026 SHALL keep held payload bit-stable while out_valid = 1 and out_ready = 0.
REQ-027 SHALL increment stall_cnt each cycle with out_valid & ~out_ready, saturating at 2^CNT_W-1; flush does not clear it.

Reset
REQ-028 SHALL, while RST_N = 0, force state EMPTY, out_valid 0, out_ctrl 0, in_ready 1, stall_cnt 0, out_data 0, out_rd 0 immediately, regardless of CLK.
REQ-029 SHALL discard in-flight entries when reset asserts mid-operation and resume accepting on the first rising CLK after RST_N deasserts.

Structure
REQ-030 SHALL take CTRL bit positions (REG_WRITE_BIT, MEM_WRITE_BIT, RESULT_SRC_LSB) and the state enum from the shared pipeline package.
REQ-031 SHALL be a single module with no sub-modules; the saturating counter stays inline.

Verification
REQ-032 Reset: RST_N=0 mid-FULL -> out_valid=0, out_ctrl=4'b0000, in_ready=1, stall_cnt=0 without a clock edge.
REQ-033 Streaming: in_valid=1, out_ready=1 for 8 cycles with alu_result=1..8 -> out alu_result 1..8 one cycle later, in_ready stays 1.
REQ-034 Backpressure: out_ready=0, push A(alu=0xA), B(alu=0xB) -> FULL, in_ready=0, stall_cnt increments per cycle; out_ready=1 -> A then B, no loss or duplication.
REQ-035 Flush: FULL plus in_valid=1 with flush=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; incoming entry never appears.
REQ-036 Saturation: CNT_W=4, hold stall 20 cycles -> stall_cnt sticks at 15.
